alu_op_sequencer: RTL and testbench

//  Front-end controller for the combinational ALU datapath and its ALUControl decode.
//  - Accepts one operation per request: ALUop, FuncCode and two operands, with a valid/ready handshake.
//  - Decodes the ALU control code and drives it to the external ALU.
//  - Captures the result and returns it on a valid/ready response channel.
//  - ALUop=2'b11 (multiply) runs as a multi-cycle shift-add loop that reuses the ALU adder.

---
 rtl/alu_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Request/response sequencer in front of an external combinational ALU; multiply is a shift-add loop on the ALU adder.
// Optional macro ALU_SEQ_EARLY_EXIT_EN ends the multiply loop once the remaining multiplier bits are all zero.
module alu_op_sequencer #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_aluop,
  input  logic [3:0]       req_funccode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

  localparam logic [3:0] CTL_ADD = 4'b0010;

  state_t             state_q, state_d;
  logic [3:0]         ctl_q, ctl_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
  logic               rsp_zero_q, rsp_zero_d;
  logic               rsp_err_q, rsp_err_d;
  logic [4:0]         dec;
  logic               mul_done;

  // Returns {illegal, alu_ctl}; aluop 11 decodes to add because multiply drives the adder.
  function automatic logic [4:0] decode(input logic [1:0] op, input logic [3:0] fc);
    logic [4:0] r;
    r = {1'b0, CTL_ADD};
    case (op)
      2'b00: r = {1'b0, CTL_ADD};
      2'b01: r = {1'b0, 4'b0110};
      2'b10: begin
        case (fc)
          4'b0000: r = {1'b0, CTL_ADD};
          4'b0010: r = {1'b0, 4'b0110};
          4'b0100: r = {1'b0, 4'b0000};
          4'b0101: r = {1'b0, 4'b0001};
          4'b1010: r = {1'b0, 4'b0111};
          default: r = {1'b1, 4'b0000};
        endcase
      end
      default: r = {1'b0, CTL_ADD};
    endcase
    return r;
  endfunction

  assign dec = decode(req_aluop, req_funccode);

`ifdef ALU_SEQ_EARLY_EXIT_EN
  assign mul_done = (cnt_q == CNT_W'(WIDTH - 1)) || (b_q[WIDTH-1:1] == '0);
`else
  assign mul_done = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d      = state_q;
    ctl_d        = ctl_q;
    a_d          = a_q;
    b_d          = b_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    req_ready    = 1'b0;
    alu_ctl      = 4'b0000;
    alu_a        = '0;
    alu_b        = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          ctl_d = dec[3:0];
          a_d   = req_a;
          b_d   = req_b;
          acc_d = '0;
          cnt_d = '0;
          if (req_aluop == 2'b11) begin
            state_d = S_MUL;
          end else if (dec[4]) begin
            rsp_result_d = '0;
            rsp_zero_d   = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = S_RESP;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        alu_ctl      = ctl_q;
        alu_a        = a_q;
        alu_b        = b_q;
        rsp_result_d = alu_result;
        rsp_zero_d   = (alu_result == '0);
        rsp_err_d    = 1'b0;
        state_d      = S_RESP;
      end
      S_MUL: begin
        alu_ctl = CTL_ADD;
        alu_a   = acc_q;
        alu_b   = b_q[0] ? a_q : '0;
        acc_d   = alu_result;
        a_d     = a_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // The final partial sum goes straight to the response register.
        if (mul_done) begin
          rsp_result_d = alu_result;
          rsp_zero_d   = (alu_result == '0);
          rsp_err_d    = 1'b0;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ctl_q        <= 4'b0000;
      a_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctl_q        <= ctl_d;
      a_q          <= a_d;
      b_q          <= b_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU; honours ALU_SEQ_EARLY_EXIT_EN for latencies.
module tb_alu_op_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_aluop;
  logic [3:0]   req_funccode;
  logic [W-1:0] req_a, req_b;
  logic [3:0]   alu_ctl;
  logic [W-1:0] alu_a, alu_b, alu_result;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero, rsp_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic [3:0] exec_ctl;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         err;
    int           lat;
  } exp_t;
  exp_t sb[$];

  alu_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_funccode(req_funccode),
    .req_a(req_a), .req_b(req_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External ALU
  always_comb begin
    alu_result = '0;
    case (alu_ctl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? W'(1) : W'(0);
      default: alu_result = '0;
    endcase
  end

  function automatic int mul_lat(input logic [W-1:0] b);
`ifdef ALU_SEQ_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < W; i++) if (b[i]) n = i + 1;
    return n + 1;
`else
    return W + 1;
`endif
  endfunction

  function automatic exp_t model(input logic [1:0] op, input logic [3:0] fc,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t x;
    x.res = '0; x.err = 1'b0; x.lat = 2;
    case (op)
      2'b00: x.res = a + b;
      2'b01: x.res = a - b;
      2'b10: begin
        case (fc)
          4'b0000: x.res = a + b;
          4'b0010: x.res = a - b;
          4'b0100: x.res = a & b;
          4'b0101: x.res = a | b;
          4'b1010: x.res = ($signed(a) < $signed(b)) ? 1 : 0;
          default: begin x.err = 1'b1; x.lat = 1; end
        endcase
      end
      default: begin x.res = a * b; x.lat = mul_lat(b); end
    endcase
    x.zero = !x.err && (x.res == '0);
    return x;
  endfunction

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic send_req(input logic [1:0] op, input logic [3:0] fc,
                          input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    req_aluop = op; req_funccode = fc; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept_timeout req_ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    accept_cyc = cyc;
    sb.push_back(model(op, fc, a, b));
    @(negedge clk);
    exec_ctl = alu_ctl;
    req_valid = 1'b0;
  endtask

  // Waits for rsp_valid, samples it, completes the handshake, returns at the next negedge.
  task automatic get_rsp(output logic [W-1:0] r, output logic z, output logic e, output int lat);
    int n = 0;
    while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      checks++; errors++;
      $display("FAIL rsp_timeout rsp_valid=%b required 1", rsp_valid);
      r = 'x; z = 1'bx; e = 1'bx; lat = -1;
      return;
    end
    r = rsp_result; z = rsp_zero; e = rsp_err;
    lat = cyc - accept_cyc + 1;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
    req_aluop = '0; req_funccode = '0; req_a = '0; req_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_rsp ready=%b valid=%b result=%h zero=%b err=%b required 1 0 0 0 0",
               req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err);
    end
    checks++;
    if ({alu_ctl, alu_a, alu_b} !== '0) begin
      errors++;
      $display("FAIL reset_alu ctl=%b a=%h b=%h required all 0", alu_ctl, alu_a, alu_b);
    end
  endtask

  task automatic test_exec_add();
    logic [W-1:0] r; logic z, e; int l; exp_t x;
    send_req(2'b10, 4'b0000, 5, 3);
    checks++;
    if (exec_ctl !== 4'b0010) begin
      errors++; $display("FAIL add_ctl got=%b required=0010", exec_ctl);
    end
    get_rsp(r, z, e, l);
    x = sb.pop_front();
    checks++;
    if ({r, z, e} !== {W'(8), 1'b0, 1'b0} || {r, z, e} !== {x.res, x.zero, x.err}) begin
      errors++; $display("FAIL add_rsp got=%h/%b/%b required=%h/%b/%b", r, z, e, x.res, x.zero, x.err);
    end
    checks++;
    if (l !== x.lat) begin
      errors++; $display("FAIL add_latency got=%0d required=%0d", l, x.lat);
    end
  endtask

  task automatic test_funccode_sweep();
    logic [3:0] fcs [4] = '{4'b0010, 4'b0100, 4'b0101, 4'b1010};
    logic [3:0] ctls[4] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
    logic [W-1:0] r; logic z, e; int l; exp_t x;
    for (int i = 0; i < 4; i++) begin
      send_req(2'b10, fcs[i], 6, 6);
      checks++;
      if (exec_ctl !== ctls[i]) begin
        errors++; $display("FAIL sweep_ctl fc=%b got=%b required=%b", fcs[i], exec_ctl, ctls[i]);
      end
      get_rsp(r, z, e, l);
      x = sb.pop_front();
      checks++;
      if ({r, z, e} !== {x.res, x.zero, x.err} || l !== x.lat) begin
        errors++;
        $display("FAIL sweep_rsp fc=%b got=%h/%b/%b lat %0d required=%h/%b/%b lat %0d",
                 fcs[i], r, z, e, l, x.res, x.zero, x.err, x.lat);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] fcs[2] = '{4'b1111, 4'b0001};
    logic [W-1:0] r; logic z, e; int l; exp_t x;
    for (int i = 0; i < 2; i++) begin
      send_req(2'b10, fcs[i], 0, 0);
      get_rsp(r, z, e, l);
      x = sb.pop_front();
      checks++;
      if ({r, z, e} !== {{W{1'b0}}, 1'b0, 1'b1} || l !== 1) begin
        errors++;
        $display("FAIL illegal fc=%b got=%h/%b/%b lat %0d required=0/0/1 lat 1", fcs[i], r, z, e, l);
      end
    end
  endtask

  task automatic test_multiply();
    logic [W-1:0] as[5] = '{32'd7, 32'hFFFF_FFFF, 32'd3, 32'd12345, 32'h8000_0001};
    logic [W-1:0] bs[5] = '{32'd9, 32'd2, 32'd0, 32'd6789, 32'hFFFF_FFFF};
    logic [W-1:0] r; logic z, e; int l; exp_t x;
    for (int i = 0; i < 5; i++) begin
      send_req(2'b11, 4'b0000, as[i], bs[i]);
      get_rsp(r, z, e, l);
      x = sb.pop_front();
      checks++;
      if ({r, z, e} !== {x.res, x.zero, x.err}) begin
        errors++;
        $display("FAIL mul_rsp a=%h b=%h got=%h/%b/%b required=%h/%b/%b",
                 as[i], bs[i], r, z, e, x.res, x.zero, x.err);
      end
      checks++;
      if (l !== x.lat) begin
        errors++; $display("FAIL mul_latency b=%h got=%0d required=%0d", bs[i], l, x.lat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r, snap; logic z, e; int l; exp_t x;
    rsp_ready = 1'b0;
    send_req(2'b00, 4'b0000, 10, 20);
    req_aluop = 2'b01; req_funccode = 4'b0000; req_a = 50; req_b = 8; req_valid = 1'b1;
    @(negedge clk);
    x = sb.pop_front();
    snap = rsp_result;
    checks++;
    if ({rsp_valid, rsp_result, rsp_zero, rsp_err} !== {1'b1, x.res, x.zero, x.err}) begin
      errors++;
      $display("FAIL bp_first valid=%b got=%h/%b/%b required=1 %h/%b/%b",
               rsp_valid, rsp_result, rsp_zero, rsp_err, x.res, x.zero, x.err);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, snap}) begin
        errors++;
        $display("FAIL bp_hold cycle=%0d valid=%b ready=%b result=%h required 1 0 %h",
                 i, rsp_valid, req_ready, rsp_result, snap);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release valid=%b ready=%b required 0 1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    accept_cyc = cyc;
    sb.push_back(model(2'b01, 4'b0000, 50, 8));
    @(negedge clk);
    req_valid = 1'b0;
    get_rsp(r, z, e, l);
    x = sb.pop_front();
    checks++;
    if ({r, z, e} !== {W'(42), 1'b0, 1'b0} || l !== x.lat) begin
      errors++; $display("FAIL bp_second got=%h lat %0d required=%h lat %0d", r, l, x.res, x.lat);
    end
  endtask

  task automatic test_reset_mul();
    int seen = 0;
    send_req(2'b11, 4'b0000, 32'h1234, 32'hFFFF_FFFF);
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    checks++;
    if ({alu_ctl, rsp_valid, req_ready} !== {4'b0010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mul_busy ctl=%b valid=%b ready=%b required 0010 0 0", alu_ctl, rsp_valid, req_ready);
    end
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({req_ready, rsp_valid, rsp_result, alu_ctl, alu_a, alu_b} !==
        {1'b1, 1'b0, {W{1'b0}}, 4'b0000, {W{1'b0}}, {W{1'b0}}}) begin
      errors++;
      $display("FAIL mul_reset ready=%b valid=%b result=%h ctl=%b a=%h required 1 0 0 0 0",
               req_ready, rsp_valid, rsp_result, alu_ctl, alu_a);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL mul_reset_no_rsp got=%0d responses required 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] fcs[7] = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b1010, 4'b1111, 4'b0011};
    logic [W-1:0] r, a, b; logic z, e; int l; exp_t x;
    logic [1:0] op;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (op == 2'b11) ? W'($urandom_range(0, 300)) : W'($urandom);
      if (i == 0) b = a;
      send_req(op, fcs[$urandom_range(0, 6)], a, b);
      get_rsp(r, z, e, l);
      x = sb.pop_front();
      checks++;
      if ({r, z, e} !== {x.res, x.zero, x.err} || l !== x.lat) begin
        errors++;
        $display("FAIL b2b_rsp op=%b a=%h b=%h got=%h/%b/%b lat %0d required=%h/%b/%b lat %0d",
                 op, a, b, r, z, e, l, x.res, x.zero, x.err, x.lat);
      end
      checks++;
      if ({req_ready, rsp_valid} !== 2'b10) begin
        errors++; $display("FAIL b2b_idle ready=%b valid=%b required 1 0", req_ready, rsp_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_exec_add();
    test_funccode_sweep();
    test_illegal();
    test_multiply();
    test_backpressure();
    test_reset_mul();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
